// File: rtl/islam_ihfaz_mano_computer_pkg.sv
// mano_pkg: shared constants and types for the Mano basic computer.
//   - word/address/sequence-counter widths
//   - opcode encoding (IR[14:12]) and register-reference bit masks
//   - T-state enum for the sequence counter
//   - small helpers for byte selection and register-op decode
package mano_pkg;

    localparam int WORD_W = 16;
    localparam int AW     = 12;
    localparam int SC_W   = 3;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_REG = 3'd7     // register-reference (I=0) or I/O (I=1)
    } opcode_e;

    typedef enum logic [SC_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } tstate_e;

    localparam logic [WORD_W-1:0] CLA = 16'h7800;
    localparam logic [WORD_W-1:0] CLE = 16'h7400;
    localparam logic [WORD_W-1:0] CMA = 16'h7200;
    localparam logic [WORD_W-1:0] CME = 16'h7100;
    localparam logic [WORD_W-1:0] CIR = 16'h7080;
    localparam logic [WORD_W-1:0] CIL = 16'h7040;
    localparam logic [WORD_W-1:0] INC = 16'h7020;
    localparam logic [WORD_W-1:0] SPA = 16'h7010;
    localparam logic [WORD_W-1:0] SNA = 16'h7008;
    localparam logic [WORD_W-1:0] SZA = 16'h7004;
    localparam logic [WORD_W-1:0] SZE = 16'h7002;
    localparam logic [WORD_W-1:0] HLT = 16'h7001;

    // True when the register-op bit carried by mask is set in the instruction.
    function automatic logic has_op(input logic [WORD_W-1:0] ir,
                                    input logic [WORD_W-1:0] mask);
        return |(ir[AW-1:0] & mask[AW-1:0]);
    endfunction

    function automatic logic [7:0] sel_byte(input logic [WORD_W-1:0] w,
                                            input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/islam_ihfaz_mano_computer_if.sv
// Interfaces for the Mano computer slice.
//   islam_ihfaz_mano_computer_if : TinyTapeout-style pin bundle.
//       harness modport drives ena/ui_in/uio_in, reads uo_out/uio_out/uio_oe;
//       chip modport is the mirror image.
//   mano_ram_if : core-to-RAM bus (byte-enabled write port, async read port).
//       master = core, slave = RAM.
interface islam_ihfaz_mano_computer_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport harness (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport chip    (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

interface mano_ram_if #(parameter int ADDR_W = 4);
    logic              we;
    logic [1:0]        be;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       rdata;

    modport master (output we, be, waddr, wdata, raddr, input rdata);
    modport slave  (input we, be, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/islam_ihfaz_mano_computer_ram.sv
// mano_ram: 2^ADDR_W x 16 RAM, no reset.
//   clk  : write clock
//   bus  : mano_ram_if slave; byte-enabled synchronous write,
//          combinational read at raddr.
module mano_ram #(
    parameter int ADDR_W = 4
) (
    input logic        clk,
    mano_ram_if.slave  bus
);
    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (bus.we && bus.be[0]) mem[bus.waddr][7:0]  <= bus.wdata[7:0];
        if (bus.we && bus.be[1]) mem[bus.waddr][15:8] <= bus.wdata[15:8];
    end

    assign bus.rdata = mem[bus.raddr];

endmodule

// File: rtl/islam_ihfaz_mano_computer.sv
// islam_ihfaz_mano_computer: Mano basic computer with on-chip program RAM.
//   clk, rst  : clock, asynchronous active-high reset
//   ena       : harness enable (unused)
//   ui_in     : [7] RUN, [5] WE, [4] BSEL, [3:0] program address
//   uio_in    : program data byte
//   uo_out    : RUN=0 -> selected byte of M[ADDR]; RUN=1 -> selected byte of AC
//   uio_out   : {S, E, 2'b00, PC[3:0]}
//   uio_oe    : all ones while RUN=1
module islam_ihfaz_mano_computer
    import mano_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic              run, pwe, bsel;
    logic [ADDR_W-1:0] paddr;

    assign run   = ui_in[7];
    assign pwe   = ui_in[5];
    assign bsel  = ui_in[4];
    assign paddr = ui_in[ADDR_W-1:0];

    logic [WORD_W-1:0] ac, dr, ir, tr;
    logic [AW-1:0]     ar, pc;
    logic              e, s, i_q, run_q;
    tstate_e           sc, sc_next;
    opcode_e           opc;
    logic              cpu_active;
    logic [WORD_W-1:0] mem_q;

    assign opc = opcode_e'(ir[14:12]);
    // Executing only once S has been set by a RUN rising edge seen last cycle.
    assign cpu_active = run && run_q && s;

    mano_ram_if #(.ADDR_W(ADDR_W)) rbus ();

    mano_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk (clk),
        .bus (rbus.slave)
    );

    assign rbus.raddr = run ? ar[ADDR_W-1:0] : paddr;
    assign mem_q      = rbus.rdata;

    // Write port mux: pin loader in program mode, CPU stores in run mode.
    always_comb begin
        rbus.we    = 1'b0;
        rbus.be    = 2'b11;
        rbus.waddr = ar[ADDR_W-1:0];
        rbus.wdata = ac;
        if (!run) begin
            rbus.we    = pwe;
            rbus.be    = bsel ? 2'b10 : 2'b01;
            rbus.waddr = paddr;
            rbus.wdata = {uio_in, uio_in};
        end else if (cpu_active) begin
            case (sc)
                T4: begin
                    if (opc == OP_STA) begin
                        rbus.we = 1'b1;
                    end else if (opc == OP_BSA) begin
                        rbus.we    = 1'b1;
                        rbus.wdata = {{(WORD_W-AW){1'b0}}, pc};
                    end
                end
                T6: begin
                    if (opc == OP_ISZ) begin
                        rbus.we    = 1'b1;
                        rbus.wdata = dr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequence counter next state.
    always_comb begin
        sc_next = sc;
        if (!run) begin
            sc_next = T0;
        end else if (cpu_active) begin
            case (sc)
                T0: sc_next = T1;
                T1: sc_next = T2;
                T2: sc_next = T3;
                T3: sc_next = (opc == OP_REG) ? T0 : T4;
                T4: sc_next = (opc == OP_STA || opc == OP_BUN) ? T0 : T5;
                T5: sc_next = (opc == OP_ISZ) ? T6 : T0;
                default: sc_next = T0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sc <= T0;
        else     sc <= sc_next;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac    <= '0;
            dr    <= '0;
            ir    <= '0;
            tr    <= '0;
            ar    <= '0;
            pc    <= '0;
            e     <= 1'b0;
            s     <= 1'b0;
            i_q   <= 1'b0;
            run_q <= 1'b0;
        end else begin
            run_q <= run;
            if (!run) begin
                pc <= '0;
                s  <= 1'b0;
            end else if (!run_q) begin
                s <= 1'b1;
            end else if (s) begin
                case (sc)
                    T0: ar <= pc;
                    T1: begin
                        ir <= mem_q;
                        pc <= pc + 1'b1;
                    end
                    T2: begin
                        ar  <= ir[AW-1:0];
                        i_q <= ir[15];
                    end
                    T3: begin
                        if (opc == OP_REG) begin
                            // I=1 is the I/O group, treated as a NOP.
                            if (!i_q) begin
                                if      (has_op(ir, CLA)) ac <= '0;
                                else if (has_op(ir, CLE)) e  <= 1'b0;
                                else if (has_op(ir, CMA)) ac <= ~ac;
                                else if (has_op(ir, CME)) e  <= ~e;
                                else if (has_op(ir, CIR)) begin
                                    ac <= {e, ac[15:1]};
                                    e  <= ac[0];
                                end else if (has_op(ir, CIL)) begin
                                    ac <= {ac[14:0], e};
                                    e  <= ac[15];
                                end
                                else if (has_op(ir, INC)) ac <= ac + 1'b1;
                                else if (has_op(ir, SPA)) begin
                                    if (!ac[15]) pc <= pc + 1'b1;
                                end else if (has_op(ir, SNA)) begin
                                    if (ac[15]) pc <= pc + 1'b1;
                                end else if (has_op(ir, SZA)) begin
                                    if (ac == '0) pc <= pc + 1'b1;
                                end else if (has_op(ir, SZE)) begin
                                    if (!e) pc <= pc + 1'b1;
                                end
                                else if (has_op(ir, HLT)) s <= 1'b0;
                            end
                        end else if (i_q) begin
                            ar <= mem_q[AW-1:0];
                        end
                    end
                    T4: begin
                        case (opc)
                            OP_AND, OP_ADD, OP_LDA, OP_ISZ: dr <= mem_q;
                            OP_BUN: pc <= ar;
                            OP_BSA: ar <= ar + 1'b1;
                            default: ;
                        endcase
                    end
                    T5: begin
                        case (opc)
                            OP_AND: ac <= ac & dr;
                            OP_ADD: {e, ac} <= {1'b0, ac} + {1'b0, dr};
                            OP_LDA: ac <= dr;
                            OP_BSA: pc <= ar;
                            OP_ISZ: dr <= dr + 1'b1;
                            default: ;
                        endcase
                    end
                    T6: begin
                        // DR already holds the incremented value stored this cycle.
                        if (opc == OP_ISZ && dr == '0) pc <= pc + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uo_out  = run ? sel_byte(ac, bsel) : sel_byte(mem_q, bsel);
    assign uio_out = {s, e, 2'b00, pc[3:0]};
    assign uio_oe  = run ? 8'hFF : 8'h00;

    logic unused_bits;
    assign unused_bits = ^{ena, ui_in[6], tr, ui_in[3:0]};

endmodule

// File: tb/tb_islam_ihfaz_mano_computer.sv
module tb_islam_ihfaz_mano_computer;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    islam_ihfaz_mano_computer_if pins ();

    islam_ihfaz_mano_computer dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (pins.ena),
        .ui_in   (pins.ui_in),
        .uio_in  (pins.uio_in),
        .uo_out  (pins.uo_out),
        .uio_out (pins.uio_out),
        .uio_oe  (pins.uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [3:0] a, input logic b, input logic [7:0] d);
        pins.ui_in  = {2'b00, 1'b1, b, a};
        pins.uio_in = d;
        tick();
        pins.ui_in  = 8'h00;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] w);
        wr_byte(a, 1'b0, w[7:0]);
        wr_byte(a, 1'b1, w[15:8]);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 16; i++) load(4'(i), 16'h0000);
    endtask

    task automatic rd_mem(input logic [3:0] a, output logic [15:0] w);
        pins.ui_in = {4'b0000, a};
        #1 w[7:0] = pins.uo_out;
        pins.ui_in = {4'b0001, a};
        #1 w[15:8] = pins.uo_out;
        pins.ui_in = 8'h00;
    endtask

    task automatic rd_ac(output logic [15:0] w);
        pins.ui_in = 8'h80;
        #1 w[7:0] = pins.uo_out;
        pins.ui_in = 8'h90;
        #1 w[15:8] = pins.uo_out;
        pins.ui_in = 8'h80;
    endtask

    task automatic do_reset;
        pins.ui_in = 8'h00;
        rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    // Raise RUN and wait for S to drop again (HLT).
    task automatic run_prog(input string tag);
        logic ok;
        ok = 1'b0;
        pins.ui_in = 8'h80;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (n > 0 && !pins.uio_out[7]) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_halted"}, {15'd0, ok}, 16'd1);
    endtask

    task automatic stop_run;
        pins.ui_in = 8'h00;
        tick();
    endtask

    logic [15:0] w;

    initial begin
        rst         = 1'b1;
        pins.ena    = 1'b1;
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;
        #12;
        chk("rst_uio_out", {8'd0, pins.uio_out}, 16'h0000);
        chk("rst_uio_oe",  {8'd0, pins.uio_oe},  16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Load / readback
        clear_mem();
        load(4'd3, 16'hBEEF);
        pins.ui_in = 8'h03;
        #1 chk("rb_lo", {8'd0, pins.uo_out}, 16'h00EF);
        chk("rb_oe", {8'd0, pins.uio_oe}, 16'h0000);
        pins.ui_in = 8'h13;
        #1 chk("rb_hi", {8'd0, pins.uo_out}, 16'h00BE);
        pins.ui_in = 8'h00;

        // Arithmetic: LDA 4; ADD 5; STA 6; HLT
        do_reset();
        clear_mem();
        load(4'd0, 16'h2004); load(4'd1, 16'h1005); load(4'd2, 16'h3006);
        load(4'd3, 16'h7001); load(4'd4, 16'h0003); load(4'd5, 16'h0005);
        run_prog("arith");
        chk("arith_s",  {15'd0, pins.uio_out[7]}, 16'd0);
        chk("arith_e",  {15'd0, pins.uio_out[6]}, 16'd0);
        chk("arith_pc", {12'd0, pins.uio_out[3:0]}, 16'd4);
        chk("arith_oe", {8'd0, pins.uio_oe}, 16'h00FF);
        pins.ui_in = 8'h80;
        #1 chk("arith_ac_lo", {8'd0, pins.uo_out}, 16'h0008);
        pins.ui_in = 8'h90;
        #1 chk("arith_ac_hi", {8'd0, pins.uo_out}, 16'h0000);
        stop_run();
        rd_mem(4'd6, w);
        chk("arith_m6", w, 16'h0008);

        // Carry: CLA; CMA; ADD 5 (=1); HLT
        do_reset();
        clear_mem();
        load(4'd0, 16'h7800); load(4'd1, 16'h7200); load(4'd2, 16'h1005);
        load(4'd3, 16'h7001); load(4'd5, 16'h0001);
        run_prog("carry");
        rd_ac(w);
        chk("carry_ac", w, 16'h0000);
        chk("carry_e", {15'd0, pins.uio_out[6]}, 16'd1);
        stop_run();

        // Carry then rotate: CLA; CMA; ADD 5; CIL; HLT
        do_reset();
        load(4'd3, 16'h7040); load(4'd4, 16'h7001);
        run_prog("rot");
        rd_ac(w);
        chk("rot_ac", w, 16'h0001);
        chk("rot_e",  {15'd0, pins.uio_out[6]}, 16'd0);
        chk("rot_pc", {12'd0, pins.uio_out[3:0]}, 16'd5);
        stop_run();

        // Indirect + ISZ skip
        do_reset();
        clear_mem();
        load(4'd0, 16'hA004); load(4'd1, 16'h6005); load(4'd2, 16'h7001);
        load(4'd3, 16'h7001); load(4'd4, 16'h0007); load(4'd5, 16'hFFFF);
        load(4'd7, 16'h1234);
        run_prog("isz");
        rd_ac(w);
        chk("isz_ac", w, 16'h1234);
        chk("isz_pc", {12'd0, pins.uio_out[3:0]}, 16'd4);
        stop_run();
        rd_mem(4'd5, w);
        chk("isz_m5", w, 16'h0000);

        // Subroutine: BSA 8; HLT; (9) INC; (10) BUN I 8
        do_reset();
        clear_mem();
        load(4'd0, 16'h5008); load(4'd1, 16'h7001);
        load(4'd9, 16'h7020); load(4'd10, 16'hC008);
        run_prog("bsa");
        rd_ac(w);
        chk("bsa_ac", w, 16'h0001);
        chk("bsa_pc", {12'd0, pins.uio_out[3:0]}, 16'd2);
        stop_run();
        rd_mem(4'd8, w);
        chk("bsa_m8", w, 16'h0001);

        // Restart after HLT: runs again from PC=0, AC held -> 2
        run_prog("restart");
        rd_ac(w);
        chk("restart_ac", w, 16'h0002);
        chk("restart_pc", {12'd0, pins.uio_out[3:0]}, 16'd2);
        stop_run();

        // Endless loop: INC; BUN 0
        do_reset();
        clear_mem();
        load(4'd0, 16'h7020); load(4'd1, 16'h4000);
        pins.ui_in = 8'h80;
        repeat (20) tick();
        rd_ac(w);
        chk("loop_ac", w, 16'h0002);
        chk("loop_s", {15'd0, pins.uio_out[7]}, 16'd1);
        // Abort by dropping RUN
        stop_run();
        chk("abort_status", {8'd0, pins.uio_out}, 16'h0000);
        chk("abort_oe", {8'd0, pins.uio_oe}, 16'h0000);
        // Resume: AC held, loop again
        pins.ui_in = 8'h80;
        repeat (20) tick();
        rd_ac(w);
        chk("resume_ac", w, 16'h0004);
        // Async reset mid-run
        rst = 1'b1;
        #1;
        chk("rstrun_ac", {8'd0, pins.uo_out}, 16'h0000);
        chk("rstrun_status", {8'd0, pins.uio_out}, 16'h0000);
        #1 rst = 1'b0;
        pins.ui_in = 8'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/islam_ihfaz_mano_computer.md
Name: islam_ihfaz_mano_computer

Overview:
- Mano "basic computer" CPU: 16-bit word, 12-bit addresses, AC/E/IR/AR/PC/DR/TR, sequence counter SC and start flag S.
- Includes a small on-chip RAM, loaded and read back through the TinyTapeout-style pin interface.
- Top-level user block: the chip harness drives pins; no other logic sits between harness and this block.

Parameters:
- ADDR_W, 4, RAM address bits (16 words). Memory uses AR[ADDR_W-1:0]; upper AR/PC bits are kept but ignored for addressing.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  harness enable; ignored
- ui_in  in  8  [7]=RUN, [5]=WE (program write), [4]=BSEL (0 low byte, 1 high byte), [3:0]=ADDR, [6] unused
- uio_in  in  8  program data byte
- uo_out  out  8  readback byte
- uio_out  out  8  status {S, E, 2'b00, PC[3:0]}
- uio_oe  out  8  0x00 when RUN=0, 0xFF when RUN=1

Behaviour:
- Reset values: AC, DR, IR, TR, AR, PC, E, S, SC = 0; RUN_q = 0; uo_out = M[0] low byte (per combinational rule); uio_out = 0x00. RAM has no reset.
- Program mode (RUN=0):
  - PC=0, SC=0, S=0 every cycle.
  - AC and E hold.
  - WE=1 writes uio_in into byte BSEL of M[ADDR] on each clk edge, level-sensitive.
  - uo_out = selected byte of M[ADDR], combinational.
- Run mode (RUN=1):
  - uo_out = AC byte selected by BSEL.
  - WE ignored.
- S is set on the cycle RUN_q=0 and RUN=1 (rising edge of RUN). HLT clears S. Restart requires dropping RUN and raising it again.
- When S=0 in run mode, all state holds.
- SC cycle per instruction, one T-state per clock:
  - T0: AR<=PC.
  - T1: IR<=M[AR]; PC<=PC+1.
  - T2: AR<=IR[11:0]; I<=IR[15]; decode D=IR[14:12].
  - T3, D=7, I=0: register ops by IR bit, then SC<=0:
    - CLA b11, CLE b10, CMA b9, CME b8.
    - CIR b7: rotate right through E. CIL b6: rotate left through E.
    - INC b5: AC+1, E unaffected.
    - SPA b4: skip if AC[15]=0. SNA b3: skip if AC[15]=1. SZA b2: skip if AC=0. SZE b1: skip if E=0. Skip means PC+1.
    - HLT b0: S<=0.
    - Exactly one bit set per instruction; multiple bits undefined.
  - T3, D=7, I=1: I/O instruction, NOP, SC<=0.
  - T3, D≠7: if I, AR<=M[AR]; else no-op.
- Memory-reference ops, from T4:
  - AND/ADD/LDA: T4 DR<=M[AR]; T5 AC<=AC&DR, or {E,AC}<=AC+DR (17-bit), or AC<=DR; SC<=0.
  - STA: T4 M[AR]<=AC; SC<=0.
  - BUN: T4 PC<=AR; SC<=0.
  - BSA: T4 M[AR]<=PC (zero-extended to 16 bits), AR<=AR+1; T5 PC<=AR; SC<=0.
  - ISZ: T4 DR<=M[AR]; T5 DR<=DR+1; T6 M[AR]<=DR, and if DR==0 then PC<=PC+1; SC<=0.
- PC and AR wrap modulo 4096. Address wrap modulo 2^ADDR_W.
- RUN dropped mid-instruction: abort immediately; PC=0, SC=0, S=0. Memory/AC changes already done remain.
- Reset mid-operation: asynchronous clear of all registers.

Decomposition:
- Package mano_pkg holds:
  - opcode constants AND..ISZ (0..6), REG/IO (7);
  - register-reference bit masks: CLA 16'h7800, CLE 7400, CMA 7200, CME 7100, CIR 7080, CIL 7040, INC 7020, SPA 7010, SNA 7008, SZA 7004, SZE 7002, HLT 7001;
  - word width 16, address width 12, SC width 3.
- One sub-module mano_ram: 2^ADDR_W x 16, one write port with byte enables, one combinational read port. The core muxes its address/data between program loader and CPU by RUN.

Test Plan:
- Load/readback: RUN=0, write bytes to M[3]=0xBEEF. Set ADDR=3: BSEL=0 -> uo_out=0xEF, BSEL=1 -> 0xBE. uio_oe=0x00.
- Arithmetic program:
  - Load M[0]=2004, M[1]=1005, M[2]=3006, M[3]=7001, M[4]=0003, M[5]=0005. Raise RUN.
  - After halt: S=0, AC=0x0008 (uo_out 0x08/0x00), E=0, PC=4. In program mode M[6] reads 0x0008.
- Carry/rotate:
  - Program M[0]=7800 CLA, 7200 CMA, 1005 ADD, 7040 CIL, 7001 HLT, M[5]=0001.
  - Required: AC=0x0000 and E=1 after ADD; after CIL AC=0x0001, E=0.
- Indirect + ISZ skip:
  - Program M[0]=A004 LDA I 4, M[1]=6005 ISZ 5, M[2]=7001, M[3]=7001, M[4]=0007, M[5]=FFFF, M[7]=1234.
  - Required: AC=0x1234, M[5]=0000, halt executed at address 3 (PC=4).
- Subroutine:
  - Program M[0]=5008 BSA 8, M[1]=7001, M[9]=7020 INC, M[10]=C008 BUN I 8.
  - Required: M[8]=0x0001, AC=0x0001 after halt, PC=2.
- Control:
  - Assert rst mid-run -> all registers 0 immediately, uio_out=0x00.
  - Toggle RUN 0->1 after HLT -> program restarts at PC=0.
